// File: rtl/bp_me_dma_bank_mux_if.sv
// Bank-side and DRAM-side DMA signals of bp_me_dma_bank_mux.
// master: the mux itself; slave: the cache banks and memory controller.
interface bp_me_dma_bank_mux_if #(
  parameter int banks_p      = 2,
  parameter int addr_width_p = 28,
  parameter int fill_width_p = 64
);
  localparam int pkt_width_lp = addr_width_p + 1;

  logic [banks_p-1:0][pkt_width_lp-1:0] bank_dma_pkt_i;
  logic [banks_p-1:0]                   bank_dma_pkt_v_i;
  logic [banks_p-1:0]                   bank_dma_pkt_ready_and_o;
  logic [banks_p-1:0][fill_width_p-1:0] bank_dma_data_i;
  logic [banks_p-1:0]                   bank_dma_data_v_i;
  logic [banks_p-1:0]                   bank_dma_data_ready_and_o;
  logic [banks_p-1:0][fill_width_p-1:0] bank_dma_data_o;
  logic [banks_p-1:0]                   bank_dma_data_v_o;
  logic [banks_p-1:0]                   bank_dma_data_ready_and_i;
  logic [pkt_width_lp-1:0]              dma_pkt_o;
  logic                                 dma_pkt_v_o;
  logic                                 dma_pkt_ready_and_i;
  logic [fill_width_p-1:0]              dma_data_i;
  logic                                 dma_data_v_i;
  logic                                 dma_data_ready_and_o;
  logic [fill_width_p-1:0]              dma_data_o;
  logic                                 dma_data_v_o;
  logic                                 dma_data_ready_and_i;

  modport master (
    input  bank_dma_pkt_i, bank_dma_pkt_v_i, bank_dma_data_i, bank_dma_data_v_i,
           bank_dma_data_ready_and_i, dma_pkt_ready_and_i, dma_data_i, dma_data_v_i,
           dma_data_ready_and_i,
    output bank_dma_pkt_ready_and_o, bank_dma_data_ready_and_o, bank_dma_data_o,
           bank_dma_data_v_o, dma_pkt_o, dma_pkt_v_o, dma_data_ready_and_o,
           dma_data_o, dma_data_v_o
  );

  modport slave (
    output bank_dma_pkt_i, bank_dma_pkt_v_i, bank_dma_data_i, bank_dma_data_v_i,
           bank_dma_data_ready_and_i, dma_pkt_ready_and_i, dma_data_i, dma_data_v_i,
           dma_data_ready_and_i,
    input  bank_dma_pkt_ready_and_o, bank_dma_data_ready_and_o, bank_dma_data_o,
           bank_dma_data_v_o, dma_pkt_o, dma_pkt_v_o, dma_data_ready_and_o,
           dma_data_o, dma_data_v_o
  );
endinterface

// File: rtl/bp_me_dma_bank_mux.sv
// Merges per-bank L2 DMA ports onto one DRAM DMA channel with in-order tag FIFOs.
// Define BP_ME_DMA_BANK_MUX_ROUND_ROBIN_EN for round-robin arbitration; default is fixed priority.
module bp_me_dma_bank_mux #(
  parameter int banks_p       = 2,
  parameter int addr_width_p  = 28,
  parameter int fill_width_p  = 64,
  parameter int block_width_p = 512,
  parameter int rd_fifo_els_p = 4,
  parameter int wr_fifo_els_p = 2
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  bp_me_dma_bank_mux_if.master bus
);
  localparam int bank_id_width_lp = (banks_p > 1) ? $clog2(banks_p) : 1;
  localparam int beats_lp         = block_width_p / fill_width_p;
  localparam int beat_width_lp    = (beats_lp > 1) ? $clog2(beats_lp) : 1;
  localparam int rd_ptr_width_lp  = (rd_fifo_els_p > 1) ? $clog2(rd_fifo_els_p) : 1;
  localparam int wr_ptr_width_lp  = (wr_fifo_els_p > 1) ? $clog2(wr_fifo_els_p) : 1;
  localparam int rd_cnt_width_lp  = $clog2(rd_fifo_els_p + 1);
  localparam int wr_cnt_width_lp  = $clog2(wr_fifo_els_p + 1);

  typedef logic [bank_id_width_lp-1:0] bank_id_t;

  bank_id_t rd_mem_q [rd_fifo_els_p];
  bank_id_t wr_mem_q [wr_fifo_els_p];
  logic [rd_ptr_width_lp-1:0] rd_wptr_q, rd_wptr_d, rd_rptr_q, rd_rptr_d;
  logic [wr_ptr_width_lp-1:0] wr_wptr_q, wr_wptr_d, wr_rptr_q, wr_rptr_d;
  logic [rd_cnt_width_lp-1:0] rd_cnt_q, rd_cnt_d;
  logic [wr_cnt_width_lp-1:0] wr_cnt_q, wr_cnt_d;
  logic [beat_width_lp-1:0]   rd_beat_q, rd_beat_d, wr_beat_q, wr_beat_d;

  logic [banks_p-1:0] elig;
  logic               grant_v, pkt_hs, rd_push, wr_push;
  bank_id_t           grant_id, rd_head, wr_head;
  logic               rd_active, wr_active, rd_beat_hs, wr_beat_hs, rd_pop, wr_pop;
  logic               rd_full, wr_full;

  // Fullness comes from registered counts only, so a same-cycle pop never frees a slot.
  assign rd_full = (rd_cnt_q == rd_cnt_width_lp'(rd_fifo_els_p));
  assign wr_full = (wr_cnt_q == wr_cnt_width_lp'(wr_fifo_els_p));

  always_comb begin
    elig = '0;
    for (int k = 0; k < banks_p; k++)
      elig[k] = bus.bank_dma_pkt_v_i[k]
              & (bus.bank_dma_pkt_i[k][addr_width_p] ? ~wr_full : ~rd_full);
  end

`ifdef BP_ME_DMA_BANK_MUX_ROUND_ROBIN_EN
  bank_id_t rr_q, rr_d;

  // Lowest eligible bank overall, overridden by the lowest one at or after the pointer.
  always_comb begin
    grant_v  = 1'b0;
    grant_id = '0;
    for (int k = banks_p - 1; k >= 0; k--)
      if (elig[k]) begin
        grant_v  = 1'b1;
        grant_id = bank_id_t'(k);
      end
    for (int k = banks_p - 1; k >= 0; k--)
      if (elig[k] && (bank_id_t'(k) >= rr_q))
        grant_id = bank_id_t'(k);
  end

  always_comb begin
    rr_d = rr_q;
    if (pkt_hs)
      rr_d = (grant_id == bank_id_t'(banks_p - 1)) ? '0 : grant_id + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) rr_q <= '0;
    else         rr_q <= rr_d;
  end
`else
  always_comb begin
    grant_v  = 1'b0;
    grant_id = '0;
    for (int k = banks_p - 1; k >= 0; k--)
      if (elig[k]) begin
        grant_v  = 1'b1;
        grant_id = bank_id_t'(k);
      end
  end
`endif

  assign rd_head   = rd_mem_q[rd_rptr_q];
  assign wr_head   = wr_mem_q[wr_rptr_q];
  assign rd_active = (rd_cnt_q != '0) & ~reset_i;
  assign wr_active = (wr_cnt_q != '0) & ~reset_i;

  always_comb begin
    bus.dma_pkt_v_o               = grant_v & ~reset_i;
    bus.dma_pkt_o                 = bus.bank_dma_pkt_i[grant_id];
    bus.bank_dma_pkt_ready_and_o  = '0;
    bus.bank_dma_pkt_ready_and_o[grant_id] = grant_v & ~reset_i & bus.dma_pkt_ready_and_i;

    bus.dma_data_o                = bus.bank_dma_data_i[wr_head];
    bus.dma_data_v_o              = wr_active & bus.bank_dma_data_v_i[wr_head];
    bus.bank_dma_data_ready_and_o = '0;
    bus.bank_dma_data_ready_and_o[wr_head] = wr_active & bus.dma_data_ready_and_i;

    bus.bank_dma_data_o           = {banks_p{bus.dma_data_i}};
    bus.bank_dma_data_v_o         = '0;
    bus.bank_dma_data_v_o[rd_head] = rd_active & bus.dma_data_v_i;
    bus.dma_data_ready_and_o      = rd_active & bus.bank_dma_data_ready_and_i[rd_head];
  end

  assign pkt_hs     = grant_v & ~reset_i & bus.dma_pkt_ready_and_i;
  assign wr_push    = pkt_hs &  bus.bank_dma_pkt_i[grant_id][addr_width_p];
  assign rd_push    = pkt_hs & ~bus.bank_dma_pkt_i[grant_id][addr_width_p];
  assign wr_beat_hs = wr_active & bus.bank_dma_data_v_i[wr_head] & bus.dma_data_ready_and_i;
  assign rd_beat_hs = rd_active & bus.bank_dma_data_ready_and_i[rd_head] & bus.dma_data_v_i;
  assign wr_pop     = wr_beat_hs & (wr_beat_q == beat_width_lp'(beats_lp - 1));
  assign rd_pop     = rd_beat_hs & (rd_beat_q == beat_width_lp'(beats_lp - 1));

  always_comb begin
    wr_beat_d = wr_beat_q;
    rd_beat_d = rd_beat_q;
    if (wr_beat_hs) wr_beat_d = wr_pop ? '0 : wr_beat_q + 1'b1;
    if (rd_beat_hs) rd_beat_d = rd_pop ? '0 : rd_beat_q + 1'b1;

    wr_wptr_d = wr_wptr_q;
    wr_rptr_d = wr_rptr_q;
    rd_wptr_d = rd_wptr_q;
    rd_rptr_d = rd_rptr_q;
    if (wr_push) wr_wptr_d = (wr_wptr_q == wr_ptr_width_lp'(wr_fifo_els_p - 1)) ? '0 : wr_wptr_q + 1'b1;
    if (wr_pop)  wr_rptr_d = (wr_rptr_q == wr_ptr_width_lp'(wr_fifo_els_p - 1)) ? '0 : wr_rptr_q + 1'b1;
    if (rd_push) rd_wptr_d = (rd_wptr_q == rd_ptr_width_lp'(rd_fifo_els_p - 1)) ? '0 : rd_wptr_q + 1'b1;
    if (rd_pop)  rd_rptr_d = (rd_rptr_q == rd_ptr_width_lp'(rd_fifo_els_p - 1)) ? '0 : rd_rptr_q + 1'b1;

    wr_cnt_d = wr_cnt_q + wr_cnt_width_lp'(wr_push) - wr_cnt_width_lp'(wr_pop);
    rd_cnt_d = rd_cnt_q + rd_cnt_width_lp'(rd_push) - rd_cnt_width_lp'(rd_pop);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rd_wptr_q <= '0;
      rd_rptr_q <= '0;
      wr_wptr_q <= '0;
      wr_rptr_q <= '0;
      rd_cnt_q  <= '0;
      wr_cnt_q  <= '0;
      rd_beat_q <= '0;
      wr_beat_q <= '0;
    end else begin
      rd_wptr_q <= rd_wptr_d;
      rd_rptr_q <= rd_rptr_d;
      wr_wptr_q <= wr_wptr_d;
      wr_rptr_q <= wr_rptr_d;
      rd_cnt_q  <= rd_cnt_d;
      wr_cnt_q  <= wr_cnt_d;
      rd_beat_q <= rd_beat_d;
      wr_beat_q <= wr_beat_d;
    end
  end

  // Tag storage needs no reset: entries are only read while the count says they are valid.
  always_ff @(posedge clk_i) begin
    if (rd_push) rd_mem_q[rd_wptr_q] <= grant_id;
    if (wr_push) wr_mem_q[wr_wptr_q] <= grant_id;
  end
endmodule

// File: tb/tb_bp_me_dma_bank_mux.sv
// Self-checking bench for bp_me_dma_bank_mux: directed scenarios plus random traffic
// checked against a queue-based reference model.
module tb_bp_me_dma_bank_mux;
  localparam int BANKS  = 2;
  localparam int AW     = 28;
  localparam int FW     = 64;
  localparam int BW     = 512;
  localparam int BEATS  = BW / FW;
  localparam int RD_ELS = 4;
  localparam int WR_ELS = 2;
  localparam int PW     = AW + 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bp_me_dma_bank_mux_if #(.banks_p(BANKS), .addr_width_p(AW), .fill_width_p(FW)) bus ();

  bp_me_dma_bank_mux #(
    .banks_p(BANKS), .addr_width_p(AW), .fill_width_p(FW), .block_width_p(BW),
    .rd_fifo_els_p(RD_ELS), .wr_fifo_els_p(WR_ELS)
  ) dut (
    .clk_i(clk), .reset_i(reset), .bus(bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // reference model: tag queues of bank ids, beat counts, next search start
  int rdq[$];
  int wrq[$];
  int rd_beat, wr_beat, rr_ptr;

  logic             exp_pkt_v;
  int               exp_gid;
  logic [PW-1:0]    exp_pkt;
  logic [BANKS-1:0] exp_pkt_rdy, exp_bank_wr_rdy, exp_fill_v;
  logic             exp_dma_v, exp_dma_rdy;
  logic [FW-1:0]    exp_dma_data;

  function automatic void model_eval();
    int b;
    exp_pkt_v = 1'b0; exp_gid = 0; exp_pkt = '0; exp_pkt_rdy = '0;
    exp_bank_wr_rdy = '0; exp_fill_v = '0; exp_dma_v = 1'b0; exp_dma_rdy = 1'b0;
    exp_dma_data = '0;
    if (reset) return;
    for (int i = 0; i < BANKS; i++) begin
`ifdef BP_ME_DMA_BANK_MUX_ROUND_ROBIN_EN
      b = (rr_ptr + i) % BANKS;
`else
      b = i;
`endif
      if (!exp_pkt_v && bus.bank_dma_pkt_v_i[b] &&
          (bus.bank_dma_pkt_i[b][AW] ? (wrq.size() < WR_ELS) : (rdq.size() < RD_ELS))) begin
        exp_pkt_v = 1'b1;
        exp_gid   = b;
      end
    end
    if (exp_pkt_v) begin
      exp_pkt = bus.bank_dma_pkt_i[exp_gid];
      exp_pkt_rdy[exp_gid] = bus.dma_pkt_ready_and_i;
    end
    if (wrq.size() > 0) begin
      exp_dma_v    = bus.bank_dma_data_v_i[wrq[0]];
      exp_dma_data = bus.bank_dma_data_i[wrq[0]];
      exp_bank_wr_rdy[wrq[0]] = bus.dma_data_ready_and_i;
    end
    if (rdq.size() > 0) begin
      exp_fill_v[rdq[0]] = bus.dma_data_v_i;
      exp_dma_rdy = bus.bank_dma_data_ready_and_i[rdq[0]];
    end
  endfunction

  function automatic void model_advance();
    bit pkt_hs, wr_hs, rd_hs;
    if (reset) begin
      rdq.delete(); wrq.delete();
      rd_beat = 0; wr_beat = 0; rr_ptr = 0;
      return;
    end
    pkt_hs = exp_pkt_v && bus.dma_pkt_ready_and_i;
    wr_hs  = exp_dma_v && bus.dma_data_ready_and_i;
    rd_hs  = (rdq.size() > 0) && bus.dma_data_v_i && exp_dma_rdy;
    if (wr_hs) begin
      wr_beat++;
      if (wr_beat == BEATS) begin wr_beat = 0; void'(wrq.pop_front()); end
    end
    if (rd_hs) begin
      rd_beat++;
      if (rd_beat == BEATS) begin rd_beat = 0; void'(rdq.pop_front()); end
    end
    if (pkt_hs) begin
      if (exp_pkt[AW]) wrq.push_back(exp_gid);
      else             rdq.push_back(exp_gid);
      rr_ptr = (exp_gid + 1) % BANKS;
    end
  endfunction

  // inputs change at posedge+1; outputs are sampled and the model evaluated at negedge
  task automatic settle();
    @(negedge clk);
    model_eval();
  endtask

  task automatic next();
    model_advance();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.bank_dma_pkt_i = '0;            bus.bank_dma_pkt_v_i = '0;
    bus.bank_dma_data_i = '0;           bus.bank_dma_data_v_i = '0;
    bus.bank_dma_data_ready_and_i = '0; bus.dma_pkt_ready_and_i = 1'b0;
    bus.dma_data_i = '0;                bus.dma_data_v_i = 1'b0;
    bus.dma_data_ready_and_i = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    settle(); next();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    bus.dma_pkt_ready_and_i = 1'b1;
    bus.bank_dma_pkt_i[0] = {1'b0, 28'h10}; bus.bank_dma_pkt_v_i = 2'b01;
    settle(); next();
    bus.bank_dma_pkt_i[1] = {1'b1, 28'h20}; bus.bank_dma_pkt_v_i = 2'b10;
    settle(); next();
    reset = 1'b1;
    bus.bank_dma_pkt_v_i = 2'b11; bus.bank_dma_data_v_i = 2'b11;
    bus.bank_dma_data_ready_and_i = 2'b11; bus.dma_data_v_i = 1'b1; bus.dma_data_ready_and_i = 1'b1;
    settle();
    n_checks++; if (bus.dma_pkt_v_o !== 1'b0) $display("FAIL reset_pkt_v got=%b exp=0", bus.dma_pkt_v_o); else n_pass++;
    n_checks++; if (bus.dma_data_v_o !== 1'b0) $display("FAIL reset_dma_data_v got=%b exp=0", bus.dma_data_v_o); else n_pass++;
    n_checks++; if (bus.dma_data_ready_and_o !== 1'b0) $display("FAIL reset_dma_ready got=%b exp=0", bus.dma_data_ready_and_o); else n_pass++;
    n_checks++; if (bus.bank_dma_pkt_ready_and_o !== 2'b00) $display("FAIL reset_bank_pkt_ready got=%b exp=00", bus.bank_dma_pkt_ready_and_o); else n_pass++;
    n_checks++; if (bus.bank_dma_data_ready_and_o !== 2'b00) $display("FAIL reset_bank_data_ready got=%b exp=00", bus.bank_dma_data_ready_and_o); else n_pass++;
    n_checks++; if (bus.bank_dma_data_v_o !== 2'b00) $display("FAIL reset_bank_fill_v got=%b exp=00", bus.bank_dma_data_v_o); else n_pass++;
    next();
    reset = 1'b0;
    bus.bank_dma_pkt_i[0] = {1'b0, 28'h30}; bus.bank_dma_pkt_v_i = 2'b01;
    settle();
    n_checks++; if (bus.dma_data_v_o !== 1'b0) $display("FAIL post_reset_wr_empty got=%b exp=0", bus.dma_data_v_o); else n_pass++;
    n_checks++; if (bus.dma_data_ready_and_o !== 1'b0) $display("FAIL post_reset_rd_empty got=%b exp=0", bus.dma_data_ready_and_o); else n_pass++;
    n_checks++; if (bus.dma_pkt_v_o !== 1'b1) $display("FAIL post_reset_pkt_v got=%b exp=1", bus.dma_pkt_v_o); else n_pass++;
    next();
    clear_inputs();
  endtask

  task automatic test_single_read();
    do_reset();
    bus.bank_dma_pkt_i[1] = {1'b0, 28'h40}; bus.bank_dma_pkt_v_i = 2'b10;
    bus.dma_pkt_ready_and_i = 1'b1; bus.dma_data_v_i = 1'b1; bus.dma_data_i = 64'hDEAD;
    bus.bank_dma_data_ready_and_i = 2'b11;
    settle();
    n_checks++; if (bus.dma_pkt_o !== 29'h0000040) $display("FAIL rd_pkt got=%h exp=0000040", bus.dma_pkt_o); else n_pass++;
    n_checks++; if (bus.bank_dma_pkt_ready_and_o !== 2'b10) $display("FAIL rd_pkt_ready got=%b exp=10", bus.bank_dma_pkt_ready_and_o); else n_pass++;
    n_checks++; if (bus.dma_data_ready_and_o !== 1'b0) $display("FAIL rd_no_bypass got=%b exp=0", bus.dma_data_ready_and_o); else n_pass++;
    next();
    bus.bank_dma_pkt_v_i = '0;
    for (int i = 0; i < BEATS; i++) begin
      bus.dma_data_i = 64'(i);
      settle();
      n_checks++; if (bus.bank_dma_data_v_o !== 2'b10) $display("FAIL rd_fill_v beat=%0d got=%b exp=10", i, bus.bank_dma_data_v_o); else n_pass++;
      n_checks++; if (bus.dma_data_ready_and_o !== 1'b1 || bus.bank_dma_data_o[1] !== 64'(i))
        $display("FAIL rd_fill_data beat=%0d got=%h/%b exp=%h/1", i, bus.bank_dma_data_o[1], bus.dma_data_ready_and_o, i);
      else n_pass++;
      next();
    end
    settle();
    n_checks++; if (bus.dma_data_ready_and_o !== 1'b0 || bus.bank_dma_data_v_o !== 2'b00)
      $display("FAIL rd_drained got=%b/%b exp=0/00", bus.dma_data_ready_and_o, bus.bank_dma_data_v_o);
    else n_pass++;
    next();
    clear_inputs();
  endtask

  task automatic test_write_backpressure();
    int sent[2];
    logic [FW-1:0] got[$];
    logic [FW-1:0] exp_beat;
    sent[0] = 0; sent[1] = 0;
    do_reset();
    bus.bank_dma_pkt_i[0] = {1'b1, 28'h80}; bus.bank_dma_pkt_i[1] = {1'b1, 28'hC0};
    bus.bank_dma_pkt_v_i = 2'b11; bus.dma_pkt_ready_and_i = 1'b1;
    settle();
    n_checks++; if (bus.dma_pkt_o !== 29'h10000080) $display("FAIL wr_pkt0 got=%h exp=10000080", bus.dma_pkt_o); else n_pass++;
    next();
    bus.bank_dma_pkt_v_i = 2'b10;
    settle();
    n_checks++; if (bus.dma_pkt_o !== 29'h100000C0 || bus.bank_dma_pkt_ready_and_o !== 2'b10)
      $display("FAIL wr_pkt1 got=%h/%b exp=100000c0/10", bus.dma_pkt_o, bus.bank_dma_pkt_ready_and_o);
    else n_pass++;
    next();
    bus.bank_dma_pkt_v_i = '0;
    bus.bank_dma_data_v_i = 2'b11;
    for (int cyc = 0; cyc < 80 && got.size() < 2 * BEATS; cyc++) begin
      bus.dma_data_ready_and_i = ((cyc % 2) == 1);
      bus.bank_dma_data_i[0] = 64'hA000 + 64'(sent[0]);
      bus.bank_dma_data_i[1] = 64'hB000 + 64'(sent[1]);
      settle();
      if (got.size() < BEATS) begin
        n_checks++; if (bus.bank_dma_data_ready_and_o[1] !== 1'b0) $display("FAIL wr_bank1_held cyc=%0d got=%b exp=0", cyc, bus.bank_dma_data_ready_and_o[1]); else n_pass++;
      end
      if (bus.dma_data_v_o === 1'b1 && bus.dma_data_ready_and_i) got.push_back(bus.dma_data_o);
      for (int k = 0; k < BANKS; k++)
        if (bus.bank_dma_data_ready_and_o[k] === 1'b1 && bus.bank_dma_data_v_i[k]) sent[k]++;
      next();
    end
    bus.bank_dma_data_v_i = '0;
    n_checks++; if (got.size() != 2 * BEATS) $display("FAIL wr_beat_count got=%0d exp=%0d", got.size(), 2 * BEATS); else n_pass++;
    for (int i = 0; i < got.size(); i++) begin
      exp_beat = (i < BEATS) ? 64'hA000 + 64'(i) : 64'hB000 + 64'(i - BEATS);
      n_checks++; if (got[i] !== exp_beat) $display("FAIL wr_beat_data idx=%0d got=%h exp=%h", i, got[i], exp_beat); else n_pass++;
    end
    clear_inputs();
  endtask

  task automatic test_arbitration();
    logic [BANKS-1:0] exp_g;
    do_reset();
    bus.bank_dma_pkt_i[0] = {1'b0, 28'h500}; bus.bank_dma_pkt_i[1] = {1'b0, 28'h540};
    bus.bank_dma_pkt_v_i = 2'b11; bus.dma_pkt_ready_and_i = 1'b1;
    for (int i = 0; i < RD_ELS; i++) begin
`ifdef BP_ME_DMA_BANK_MUX_ROUND_ROBIN_EN
      exp_g = ((i % 2) == 0) ? 2'b01 : 2'b10;
`else
      exp_g = 2'b01;
`endif
      settle();
      n_checks++; if (bus.bank_dma_pkt_ready_and_o !== exp_g) $display("FAIL arb_grant idx=%0d got=%b exp=%b", i, bus.bank_dma_pkt_ready_and_o, exp_g); else n_pass++;
      next();
    end
    settle();
    n_checks++; if (bus.dma_pkt_v_o !== 1'b0) $display("FAIL arb_rd_full got=%b exp=0", bus.dma_pkt_v_o); else n_pass++;
    next();
    clear_inputs();
  endtask

  task automatic test_fifo_full();
    do_reset();
    bus.bank_dma_pkt_i[0] = {1'b0, 28'h100}; bus.bank_dma_pkt_v_i = 2'b01;
    bus.dma_pkt_ready_and_i = 1'b1;
    for (int i = 0; i < RD_ELS; i++) begin
      settle();
      n_checks++; if (bus.bank_dma_pkt_ready_and_o !== 2'b01) $display("FAIL full_accept idx=%0d got=%b exp=01", i, bus.bank_dma_pkt_ready_and_o); else n_pass++;
      next();
    end
    settle();
    n_checks++; if (bus.dma_pkt_v_o !== 1'b0 || bus.bank_dma_pkt_ready_and_o !== 2'b00)
      $display("FAIL full_fifth_read got=%b/%b exp=0/00", bus.dma_pkt_v_o, bus.bank_dma_pkt_ready_and_o);
    else n_pass++;
    next();
    bus.bank_dma_pkt_i[1] = {1'b1, 28'h200}; bus.bank_dma_pkt_v_i = 2'b11;
    settle();
    n_checks++; if (bus.dma_pkt_v_o !== 1'b1 || bus.dma_pkt_o !== 29'h10000200 || bus.bank_dma_pkt_ready_and_o !== 2'b10)
      $display("FAIL full_write_granted got=%b/%h/%b exp=1/10000200/10", bus.dma_pkt_v_o, bus.dma_pkt_o, bus.bank_dma_pkt_ready_and_o);
    else n_pass++;
    next();
    clear_inputs();
  endtask

  task automatic test_concurrent();
    do_reset();
    bus.bank_dma_pkt_i[0] = {1'b0, 28'h300}; bus.bank_dma_pkt_i[1] = {1'b1, 28'h340};
    bus.bank_dma_pkt_v_i = 2'b11; bus.dma_pkt_ready_and_i = 1'b1;
    settle(); next();
    bus.bank_dma_pkt_v_i = 2'b10;
    settle(); next();
    bus.bank_dma_pkt_v_i = '0;
    bus.dma_data_v_i = 1'b1; bus.bank_dma_data_ready_and_i = 2'b11;
    bus.dma_data_ready_and_i = 1'b1; bus.bank_dma_data_v_i = 2'b11;
    for (int i = 0; i < BEATS; i++) begin
      bus.dma_data_i = 64'hF000 + 64'(i);
      bus.bank_dma_data_i[1] = 64'hE000 + 64'(i);
      bus.bank_dma_data_i[0] = 64'hBAD0 + 64'(i);
      settle();
      n_checks++; if (bus.bank_dma_data_v_o !== 2'b01 || bus.dma_data_ready_and_o !== 1'b1 || bus.bank_dma_data_o[0] !== 64'hF000 + 64'(i))
        $display("FAIL conc_fill beat=%0d got=%b/%b/%h exp=01/1/%h", i, bus.bank_dma_data_v_o, bus.dma_data_ready_and_o, bus.bank_dma_data_o[0], 64'hF000 + 64'(i));
      else n_pass++;
      n_checks++; if (bus.dma_data_v_o !== 1'b1 || bus.dma_data_o !== 64'hE000 + 64'(i) || bus.bank_dma_data_ready_and_o !== 2'b10)
        $display("FAIL conc_write beat=%0d got=%b/%h/%b exp=1/%h/10", i, bus.dma_data_v_o, bus.dma_data_o, bus.bank_dma_data_ready_and_o, 64'hE000 + 64'(i));
      else n_pass++;
      next();
    end
    settle();
    n_checks++; if (bus.dma_data_ready_and_o !== 1'b0 || bus.dma_data_v_o !== 1'b0)
      $display("FAIL conc_done got=%b/%b exp=0/0", bus.dma_data_ready_and_o, bus.dma_data_v_o);
    else n_pass++;
    next();
    clear_inputs();
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.bank_dma_pkt_i[1] = {1'b0, 28'h400}; bus.bank_dma_pkt_v_i = 2'b10;
    bus.dma_pkt_ready_and_i = 1'b1;
    settle(); next();
    bus.bank_dma_pkt_v_i = '0;
    bus.dma_data_v_i = 1'b1; bus.bank_dma_data_ready_and_i = 2'b11;
    for (int i = 0; i < 3; i++) begin settle(); next(); end
    reset = 1'b1;
    bus.bank_dma_pkt_v_i = 2'b11; bus.bank_dma_data_v_i = 2'b11; bus.dma_data_ready_and_i = 1'b1;
    settle();
    n_checks++; if ({bus.dma_pkt_v_o, bus.dma_data_v_o, bus.dma_data_ready_and_o} !== 3'b000)
      $display("FAIL mid_reset_dma got=%b exp=000", {bus.dma_pkt_v_o, bus.dma_data_v_o, bus.dma_data_ready_and_o});
    else n_pass++;
    n_checks++; if ({bus.bank_dma_pkt_ready_and_o, bus.bank_dma_data_ready_and_o, bus.bank_dma_data_v_o} !== 6'b0)
      $display("FAIL mid_reset_bank got=%b exp=000000", {bus.bank_dma_pkt_ready_and_o, bus.bank_dma_data_ready_and_o, bus.bank_dma_data_v_o});
    else n_pass++;
    next();
    reset = 1'b0;
    clear_inputs();
    bus.dma_data_v_i = 1'b1; bus.bank_dma_data_ready_and_i = 2'b11; bus.dma_pkt_ready_and_i = 1'b1;
    settle();
    n_checks++; if (bus.dma_data_ready_and_o !== 1'b0) $display("FAIL mid_reset_dropped got=%b exp=0", bus.dma_data_ready_and_o); else n_pass++;
    next();
    bus.bank_dma_pkt_i[0] = {1'b0, 28'h440}; bus.bank_dma_pkt_v_i = 2'b01;
    settle(); next();
    bus.bank_dma_pkt_v_i = '0;
    for (int i = 0; i < BEATS; i++) begin
      bus.dma_data_i = 64'h7700 + 64'(i);
      settle();
      n_checks++; if (bus.bank_dma_data_v_o !== 2'b01 || bus.bank_dma_data_o[0] !== 64'h7700 + 64'(i))
        $display("FAIL mid_fresh_fill beat=%0d got=%b/%h exp=01/%h", i, bus.bank_dma_data_v_o, bus.bank_dma_data_o[0], 64'h7700 + 64'(i));
      else n_pass++;
      next();
    end
    settle();
    n_checks++; if (bus.dma_data_ready_and_o !== 1'b0) $display("FAIL mid_fresh_done got=%b exp=0", bus.dma_data_ready_and_o); else n_pass++;
    next();
    clear_inputs();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 800; c++) begin
      reset = ($urandom_range(0, 99) == 0);
      for (int k = 0; k < BANKS; k++) begin
        bus.bank_dma_pkt_i[k]  = {($urandom_range(0, 2) == 0), AW'($urandom)};
        bus.bank_dma_data_i[k] = {$urandom, $urandom};
      end
      bus.bank_dma_pkt_v_i          = BANKS'($urandom);
      bus.bank_dma_data_v_i         = BANKS'($urandom);
      bus.bank_dma_data_ready_and_i = BANKS'($urandom);
      bus.dma_pkt_ready_and_i       = ($urandom_range(0, 3) != 0);
      bus.dma_data_i                = {$urandom, $urandom};
      bus.dma_data_v_i              = ($urandom_range(0, 3) != 0);
      bus.dma_data_ready_and_i      = ($urandom_range(0, 3) != 0);
      settle();
      n_checks++; if (bus.dma_pkt_v_o !== exp_pkt_v) $display("FAIL rnd_pkt_v cyc=%0d got=%b exp=%b", c, bus.dma_pkt_v_o, exp_pkt_v); else n_pass++;
      if (exp_pkt_v) begin
        n_checks++; if (bus.dma_pkt_o !== exp_pkt) $display("FAIL rnd_pkt cyc=%0d got=%h exp=%h", c, bus.dma_pkt_o, exp_pkt); else n_pass++;
      end
      n_checks++; if (bus.bank_dma_pkt_ready_and_o !== exp_pkt_rdy) $display("FAIL rnd_pkt_ready cyc=%0d got=%b exp=%b", c, bus.bank_dma_pkt_ready_and_o, exp_pkt_rdy); else n_pass++;
      n_checks++; if (bus.dma_data_v_o !== exp_dma_v) $display("FAIL rnd_wr_v cyc=%0d got=%b exp=%b", c, bus.dma_data_v_o, exp_dma_v); else n_pass++;
      if (exp_dma_v) begin
        n_checks++; if (bus.dma_data_o !== exp_dma_data) $display("FAIL rnd_wr_data cyc=%0d got=%h exp=%h", c, bus.dma_data_o, exp_dma_data); else n_pass++;
      end
      n_checks++; if (bus.bank_dma_data_ready_and_o !== exp_bank_wr_rdy) $display("FAIL rnd_wr_ready cyc=%0d got=%b exp=%b", c, bus.bank_dma_data_ready_and_o, exp_bank_wr_rdy); else n_pass++;
      n_checks++; if (bus.bank_dma_data_v_o !== exp_fill_v) $display("FAIL rnd_fill_v cyc=%0d got=%b exp=%b", c, bus.bank_dma_data_v_o, exp_fill_v); else n_pass++;
      n_checks++; if (bus.dma_data_ready_and_o !== exp_dma_rdy) $display("FAIL rnd_fill_ready cyc=%0d got=%b exp=%b", c, bus.dma_data_ready_and_o, exp_dma_rdy); else n_pass++;
      for (int k = 0; k < BANKS; k++) begin
        n_checks++; if (bus.bank_dma_data_o[k] !== bus.dma_data_i) $display("FAIL rnd_fill_bcast cyc=%0d bank=%0d got=%h exp=%h", c, k, bus.bank_dma_data_o[k], bus.dma_data_i); else n_pass++;
      end
      next();
    end
    reset = 1'b0;
    clear_inputs();
  endtask

  initial begin
    reset = 1'b1;
    rd_beat = 0; wr_beat = 0; rr_ptr = 0;
    clear_inputs();
    @(posedge clk); #1;
    test_reset();
    test_single_read();
    test_write_backpressure();
    test_arbitration();
    test_fifo_full();
    test_concurrent();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/bp_me_dma_bank_mux.md
# bp_me_dma_bank_mux

Merges the per-bank DMA interfaces of an L2 cache slice onto one DRAM-side DMA channel. Arbitrates DMA packets among `banks_p` banks and records the grant order. Steers write-data beats from the owning bank. Routes returning read-fill beats back to the requesting bank in order. Sits between the `bsg_cache` banks of `bp_me_cache_slice` and the memory controller, so the slice can expose a single DMA port regardless of bank count.

## Interface
- `banks_p`, 2: number of cache banks; ≥1; `bank_id_width_lp = max(1, $clog2(banks_p))`.
- `addr_width_p`, 28: DMA address width; packet width `pkt_width_lp = addr_width_p+1`; bit `[addr_width_p]` = write_not_read.
- `fill_width_p`, 64: DMA data beat width.
- `block_width_p`, 512: cache block bits; `beats_lp = block_width_p/fill_width_p`, ≥1, exact division required.
- `rd_fifo_els_p`, 4: outstanding read-tag capacity.
- `wr_fifo_els_p`, 2: outstanding write-tag capacity.
- `clk_i`  in  1  clock.
- `reset_i`  in  1  synchronous, active-high reset.
- `bank_dma_pkt_i`  in  banks_p×pkt_width_lp  per-bank DMA packet.
- `bank_dma_pkt_v_i`  in  banks_p  packet valid.
- `bank_dma_pkt_ready_and_o`  out  banks_p  packet accepted when v&ready.
- `bank_dma_data_i`  in  banks_p×fill_width_p  write (evict) data from banks.
- `bank_dma_data_v_i`  in  banks_p  write data valid.
- `bank_dma_data_ready_and_o`  out  banks_p  write data ready.
- `bank_dma_data_o`  out  banks_p×fill_width_p  read fill to banks (broadcast).
- `bank_dma_data_v_o`  out  banks_p  fill valid, one-hot or zero.
- `bank_dma_data_ready_and_i`  in  banks_p  fill ready.
- `dma_pkt_o`  out  pkt_width_lp  merged packet.
- `dma_pkt_v_o` / `dma_pkt_ready_and_i`  out/in  1  packet handshake.
- `dma_data_i` / `dma_data_v_i` / `dma_data_ready_and_o`  in/in/out  fill_width_p/1/1  read fill from DRAM.
- `dma_data_o` / `dma_data_v_o` / `dma_data_ready_and_i`  out/out/in  fill_width_p/1/1  write data to DRAM.

## Operation
- Eligibility: bank k is eligible when `bank_dma_pkt_v_i[k]` is set and its tag FIFO is not full (read FIFO for reads, write FIFO for writes). Fullness is taken from registered counts. A push into a full FIFO is never allowed, even with a same-cycle pop.
- Arbiter: selects one eligible bank per cycle and drives `dma_pkt_o` = that bank's packet with `dma_pkt_v_o`=1. The grant is combinational and has zero latency. `bank_dma_pkt_ready_and_o[g] = dma_pkt_ready_and_i` for the grantee only; 0 for all other banks.
- On packet handshake, the granted bank ID is pushed to the read FIFO or the write FIFO according to bit `[addr_width_p]`.
- Write path: when the write FIFO is non-empty and the head is bank h:
  - `dma_data_o = bank_dma_data_i[h]` and `dma_data_v_o = bank_dma_data_v_i[h]`.
  - `bank_dma_data_ready_and_o[h] = dma_data_ready_and_i`; all other banks see ready 0.
  - A beat counter counts handshakes; on beat `beats_lp-1` the counter clears and the write FIFO pops.
- Read path: when the read FIFO is non-empty and the head is bank h:
  - `bank_dma_data_v_o[h] = dma_data_v_i` and `dma_data_ready_and_o = bank_dma_data_ready_and_i[h]`.
  - The read counter pops the head after `beats_lp` handshakes.
  - When the read FIFO is empty, `dma_data_ready_and_o`=0.
- Read and write paths are independent and may each complete a beat in the same cycle.
- Packet order to DRAM equals tag-FIFO order. DRAM returns reads in order and consumes write data in packet order.

## Timing
- Reset values: `dma_pkt_v_o`, `dma_data_v_o`, `dma_data_ready_and_o`, all `bank_*_ready_and_o` and `bank_dma_data_v_o` = 0. FIFOs are empty, counters are 0, and the round-robin pointer is 0.
- FIFO push is visible the cycle after the packet handshake; there is no bypass. Earliest write beat or read-fill acceptance is one cycle after the packet handshake.
- Beat paths are combinational pass-through with zero added latency and one beat per cycle sustained.
- Fill beats arriving while the read FIFO is empty are not accepted.
- Reset mid-operation clears FIFOs and counters. Partially transferred blocks are dropped, and the reset cycle itself asserts no valid or ready.

## Configuration
- `BP_ME_DMA_BANK_MUX_ROUND_ROBIN_EN`:
  - Defined: round-robin arbitration. The search starts at `(last_granted+1) mod banks_p`, and the pointer updates only on a packet handshake.
  - Undefined: fixed priority, where the lowest-index eligible bank wins and no pointer register exists.

## Test plan
- Single read, banks_p=2, beats_lp=8: bank1 issues read addr 0x40 → `dma_pkt_o`=0x0000040 (bit28=0). Eight DRAM beats 0..7 then reach only `bank_dma_data_v_o[1]`, and the read FIFO empties.
- Write with backpressure: bank0 issues a write to addr 0x80, and `dma_data_ready_and_i` toggles every cycle → exactly 8 beats forwarded in order. Bank1 write data is held (ready 0) until bank0's last beat.
- Round-robin (macro defined): banks 0 and 1 both continuously request reads → grants alternate 0,1,0,1. With the macro undefined, all grants go to bank 0 until its FIFO fills at `rd_fifo_els_p`=4.
- FIFO full: four reads are accepted with no fills returned, then a fifth read → `dma_pkt_v_o`=0 for it. A pending write from another bank is still granted.
- Concurrent: a read fill and a write beat in the same cycles → both complete in 8 cycles with no cross-steering.
- Reset asserted after 3 of 8 fill beats → all outputs are 0 the next cycle, and a fresh read completes normally.
